// File: rtl/simplebus_mem_follower.sv
// Memory follower for the multiplexed simple bus: multi-beat address, programmable read
// latency, write-data timeout and range checking. Define SIMPLEBUS_MEM_CLEAR_EN to zero memory after reset.
module simplebus_mem_follower #(
  parameter int BUS_W      = 8,
  parameter int ADDR_BEATS = 2,
  parameter int MEM_DEPTH  = 256,
  parameter int READ_LAT   = 1,
  parameter int WR_TIMEOUT = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             read,
  input  logic [BUS_W-1:0] address,
  input  logic [BUS_W-1:0] data_in,
  input  logic             dv_in,
  output logic [BUS_W-1:0] data_out,
  output logic             data_oe,
  output logic             dv_out,
  output logic             dv_oe,
  output logic             busy,
  output logic             err
);

  localparam int AW     = BUS_W * ADDR_BEATS;
  localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int BEAT_W = (ADDR_BEATS > 1) ? $clog2(ADDR_BEATS) : 1;
  localparam int LAT_W  = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam int TO_W   = (WR_TIMEOUT > 1) ? $clog2(WR_TIMEOUT) : 1;
  // One extra bit so MEM_DEPTH == 2**AW is representable.
  localparam logic [AW:0] DEPTH_LIM = (AW+1)'(MEM_DEPTH);

  generate
    if (READ_LAT < 1) begin : g_bad_lat
      $error("READ_LAT must be at least 1");
    end
    if ((MEM_DEPTH < 1) || ($clog2(MEM_DEPTH) > AW)) begin : g_bad_depth
      $error("MEM_DEPTH must lie in 1..2**(BUS_W*ADDR_BEATS)");
    end
  endgenerate

`ifdef SIMPLEBUS_MEM_CLEAR_EN
  typedef enum logic [2:0] {IDLE, ADDR, RLAT, RDATA, WDATA, CLEAR} state_t;
  localparam state_t RESET_STATE = CLEAR;
`else
  typedef enum logic [2:0] {IDLE, ADDR, RLAT, RDATA, WDATA} state_t;
  localparam state_t RESET_STATE = IDLE;
`endif

  state_t            state_q;
  logic [AW-1:0]     addr_q;
  logic [AW-1:0]     addr_d;
  logic [BEAT_W-1:0] beat_q;
  logic [LAT_W-1:0]  lat_q;
  logic [TO_W-1:0]   to_q;
  logic              dv_q;
  logic              rd_gate_q;
  logic              err_q;
`ifdef SIMPLEBUS_MEM_CLEAR_EN
  logic [IDX_W-1:0]  clr_q;
`endif

  logic [BUS_W-1:0]  mem [MEM_DEPTH];
  logic [BUS_W-1:0]  rd_word_q;
  logic [AW-1:0]     rd_addr;
  logic [IDX_W-1:0]  rd_idx;
  logic              rd_hit;
  logic              wr_hit;
  logic              final_beat;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_widx;
  logic [BUS_W-1:0]  mem_wdata;

  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < DEPTH_LIM;
  endfunction

  function automatic logic [IDX_W-1:0] to_idx(input logic [AW-1:0] a);
    return a[IDX_W-1:0];
  endfunction

  // Address beats shift in from the LS end, so the first beat ends up most significant.
  generate
    if (ADDR_BEATS == 1) begin : g_one_beat
      assign addr_d = address;
    end else begin : g_multi_beat
      assign addr_d = {addr_q[AW-BUS_W-1:0], address};
    end
  endgenerate

  always_comb begin
    final_beat = ((state_q == ADDR) && (beat_q == BEAT_W'(ADDR_BEATS - 1)))
              || ((ADDR_BEATS == 1) && (state_q == IDLE) && start);
    // The RDATA read is issued on the edge entering RDATA: from RLAT the address is
    // already registered, otherwise it is still being completed by the current beat.
    rd_addr = (state_q == RLAT) ? addr_q : addr_d;
    rd_idx  = to_idx(rd_addr);
    rd_hit  = in_range(rd_addr);
    wr_hit  = in_range(addr_q);
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_widx  = to_idx(addr_q);
    mem_wdata = data_in;
    if (!reset && (state_q == WDATA) && dv_in && wr_hit) begin
      mem_we = 1'b1;
    end
`ifdef SIMPLEBUS_MEM_CLEAR_EN
    if (state_q == CLEAR) begin
      mem_we    = !reset;
      mem_widx  = clr_q;
      mem_wdata = '0;
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_widx] <= mem_wdata;
    end
    rd_word_q <= mem[rd_idx];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= RESET_STATE;
      addr_q    <= '0;
      beat_q    <= '0;
      lat_q     <= '0;
      to_q      <= '0;
      dv_q      <= 1'b0;
      rd_gate_q <= 1'b0;
      err_q     <= 1'b0;
`ifdef SIMPLEBUS_MEM_CLEAR_EN
      clr_q     <= '0;
`endif
    end else begin
      dv_q      <= 1'b0;
      rd_gate_q <= 1'b0;
      err_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            addr_q  <= addr_d;
            beat_q  <= BEAT_W'(1);
            state_q <= ADDR;
          end
        end
        ADDR: begin
          addr_q <= addr_d;
          beat_q <= beat_q + BEAT_W'(1);
        end
        RLAT: begin
          if (lat_q == LAT_W'(READ_LAT - 2)) begin
            state_q   <= RDATA;
            dv_q      <= 1'b1;
            rd_gate_q <= rd_hit;
            err_q     <= ~rd_hit;
          end else begin
            lat_q <= lat_q + LAT_W'(1);
          end
        end
        RDATA: begin
          state_q <= IDLE;
        end
        WDATA: begin
          // Data arriving on the expiry cycle still wins over the timeout.
          if (dv_in) begin
            state_q <= IDLE;
            err_q   <= ~wr_hit;
          end else if ((WR_TIMEOUT > 0) && (to_q == TO_W'(WR_TIMEOUT - 1))) begin
            state_q <= IDLE;
            err_q   <= 1'b1;
          end else begin
            to_q <= to_q + TO_W'(1);
          end
        end
`ifdef SIMPLEBUS_MEM_CLEAR_EN
        CLEAR: begin
          clr_q <= clr_q + IDX_W'(1);
          if (clr_q == IDX_W'(MEM_DEPTH - 1)) begin
            state_q <= IDLE;
          end
        end
`endif
        default: begin
          state_q <= IDLE;
        end
      endcase

      if (final_beat) begin
        if (!read) begin
          state_q <= WDATA;
          to_q    <= '0;
        end else if (READ_LAT == 1) begin
          state_q   <= RDATA;
          dv_q      <= 1'b1;
          rd_gate_q <= rd_hit;
          err_q     <= ~rd_hit;
        end else begin
          state_q <= RLAT;
          lat_q   <= '0;
        end
      end
    end
  end

  assign data_out = rd_gate_q ? rd_word_q : '0;
  assign data_oe  = dv_q;
  assign dv_out   = dv_q;
  assign dv_oe    = dv_q;
  assign busy     = (state_q != IDLE);
  assign err      = err_q;

endmodule
